writeback_unit: RTL and testbench
=================================

// Module: writeback_unit
// PURPOSE
//   Producer side of the register file write port: collects completed results from the ALU
//   and load paths over valid/ready handshakes, buffers and arbitrates them, sign/zero-extends
//   load data, and drives write_address/write_data/write_enable (one write per cycle).
//   Sits between execute/memory stages and register_file; also counts retired instructions.
// PARAMETERS
//   XLEN        32  data width
//   REG_ADDR_W  5   register index width
// PORTS
//   clk            in   1          clock, all state on posedge
//   rst            in   1          reset, asynchronous, active-low
//   flush          in   1          sync discard of buffered (not yet selected) results
//   alu_valid      in   1          ALU result offered
//   alu_ready      out  1          ALU holding slot can accept
//   alu_rd         in   REG_ADDR_W ALU destination register
//   alu_data       in   XLEN       ALU result
//   mem_valid      in   1          load result offered
//   mem_ready      out  1          load holding slot can accept
//   mem_rd         in   REG_ADDR_W load destination register
//   mem_data       in   XLEN       raw aligned memory word
//   mem_funct3     in   3          load type (RV32I encoding)
//   mem_addr_lo    in   2          byte offset of load address
//   write_address  out  REG_ADDR_W to register_file
//   write_data     out  XLEN       to register_file
//   write_enable   out  1          to register_file
//   illegal_load   out  1          1-cycle pulse: drained load had unsupported funct3
//   instret        out  64         retired-result counter
// BEHAVIOUR
//   - Reset (rst=0, async): both holding slots empty, write_enable=0, write_address=0,
//     write_data=0, illegal_load=0, instret=0, rr_ptr=ALU.
//   - Each source has one holding slot. Handshake on edge where valid&&ready; data captured.
//     ready = !flush && (slot empty || slot selected this cycle) -> back-to-back per source.
//   - Select: one occupied slot per cycle. Only one occupied -> it. Both -> round-robin
//     pointer (starts ALU, toggles after each contested grant). Selected slot frees same edge.
//   - Output regs load on select edge: accept at E0, write_enable high E1..E2, regfile
//     commits at E2 (latency 2). No select -> write_enable=0 (address/data hold last value).
//   - rd==0: drained normally, counted in instret, write_enable stays 0.
//   - Load extension (in load_extender, applied at drain): 000 LB sext byte[addr_lo];
//     001 LH sext half[addr_lo[1]]; 010 LW word; 100 LBU zext byte; 101 LHU zext half.
//     addr_lo[0] ignored for halfwords. Other funct3: write_enable=0, illegal_load=1 for
//     one cycle, still counted in instret.
//   - instret += 1 per drained entry, 64-bit, wraps 2^64-1 -> 0.
//   - flush=1: both slots cleared at edge, nothing accepted that cycle; an entry selected in
//     the same cycle is dropped (no write); output regs already loaded still commit.
//   - Reset mid-operation: all buffered and pending writes discarded immediately.
// STRUCTURE
//   - wb_pkg: XLEN/REG_ADDR_W constants, load_funct3_e enum (LB,LH,LW,LBU,LHU),
//     wb_entry_t struct {rd, data, funct3, addr_lo, is_load}.
//   - Sub-module load_extender (combinational: data, funct3, addr_lo -> value, illegal).
//   - Top: two wb_entry_t slots, rr_ptr flop, output regs, instret counter.
// TESTING
//   1 ALU rd=5 data=0xDEADBEEF at E0 -> write_enable=1, addr=5, data=0xDEADBEEF in E1 only.
//   2 Load mem_data=0x80FF7F01, LB addr_lo=2 -> 0xFFFFFFFF; LBU addr_lo=3 -> 0x00000080;
//     LH addr_lo=2 -> 0xFFFF80FF; LHU addr_lo=0 -> 0x00007F01.
//   3 Both valid every cycle, 4 each -> writes alternate ALU,MEM,ALU,... 8 writes, instret=8.
//   4 ALU rd=0 data=0x1234 -> write_enable stays 0, instret +1.
//   5 funct3=011 load -> illegal_load pulse 1 cycle, no write; flush with both slots full ->
//     no writes, ready=0 that cycle, instret unchanged.
//   6 Assert rst low mid-stream with slots full -> outputs 0 asynchronously, no later writes.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared widths, load encodings and the holding-slot record for the writeback unit.
package wb_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
        logic [2:0]            funct3;
        logic [1:0]            addr_lo;
        logic                  is_load;
    } wb_entry_t;

    // Round-robin pointer values: which source wins the next contested grant.
    localparam logic RR_ALU = 1'b0;
    localparam logic RR_MEM = 1'b1;
endpackage

// File: rtl/load_extender.sv
// Picks the addressed byte/halfword out of an aligned memory word and sign/zero-extends it.
module load_extender
    import wb_pkg::*;
(
    input  logic [XLEN-1:0] data,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    output logic [XLEN-1:0] value,
    output logic            illegal
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Halfwords only look at addr_lo[1]; misaligned low bit is ignored.
    assign byte_sel = 8'(data >> {addr_lo, 3'b000});
    assign half_sel = addr_lo[1] ? data[31:16] : data[15:0];

    always_comb begin
        value   = '0;
        illegal = 1'b0;
        case (funct3)
            LB:      value = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            LH:      value = {{(XLEN-16){half_sel[15]}}, half_sel};
            LW:      value = data;
            LBU:     value = {{(XLEN-8){1'b0}}, byte_sel};
            LHU:     value = {{(XLEN-16){1'b0}}, half_sel};
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/writeback_unit.sv
// Buffers ALU and load results in one slot each, arbitrates them round-robin and drives
// the register-file write port, counting every drained result in instret.
module writeback_unit
    import wb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [XLEN-1:0]       mem_data,
    input  logic [2:0]            mem_funct3,
    input  logic [1:0]            mem_addr_lo,
    output logic [REG_ADDR_W-1:0] write_address,
    output logic [XLEN-1:0]       write_data,
    output logic                  write_enable,
    output logic                  illegal_load,
    output logic [63:0]           instret
);
    wb_entry_t             alu_slot_q, alu_slot_d, mem_slot_q, mem_slot_d, sel_entry;
    logic                  alu_full_q, alu_full_d, mem_full_q, mem_full_d;
    logic                  rr_ptr_q, rr_ptr_d;
    logic [REG_ADDR_W-1:0] write_address_q, write_address_d;
    logic [XLEN-1:0]       write_data_q, write_data_d;
    logic                  write_enable_q, write_enable_d;
    logic                  illegal_load_q, illegal_load_d;
    logic [63:0]           instret_q, instret_d;
    logic                  sel_alu, sel_mem, drain, contested;
    logic [XLEN-1:0]       ext_value, result;
    logic                  ext_illegal, bad_load;

    load_extender u_load_extender (
        .data    (sel_entry.data),
        .funct3  (sel_entry.funct3),
        .addr_lo (sel_entry.addr_lo),
        .value   (ext_value),
        .illegal (ext_illegal)
    );

    always_comb begin
        contested = alu_full_q && mem_full_q;
        sel_alu   = alu_full_q && (!mem_full_q || rr_ptr_q == RR_ALU);
        sel_mem   = mem_full_q && (!alu_full_q || rr_ptr_q == RR_MEM);
        sel_entry = sel_alu ? alu_slot_q : mem_slot_q;
        // A result selected during a flush is dropped, not retired.
        drain     = (sel_alu || sel_mem) && !flush;
        bad_load  = sel_entry.is_load && ext_illegal;
        result    = sel_entry.is_load ? ext_value : sel_entry.data;
        alu_ready = !flush && (!alu_full_q || sel_alu);
        mem_ready = !flush && (!mem_full_q || sel_mem);
    end

    always_comb begin
        alu_slot_d = alu_slot_q;
        alu_full_d = alu_full_q;
        mem_slot_d = mem_slot_q;
        mem_full_d = mem_full_q;
        if (flush) begin
            alu_full_d = 1'b0;
            mem_full_d = 1'b0;
        end else begin
            if (alu_valid && alu_ready) begin
                alu_full_d = 1'b1;
                alu_slot_d = '{rd: alu_rd, data: alu_data, funct3: 3'b000,
                               addr_lo: 2'b00, is_load: 1'b0};
            end else if (sel_alu) begin
                alu_full_d = 1'b0;
            end
            if (mem_valid && mem_ready) begin
                mem_full_d = 1'b1;
                mem_slot_d = '{rd: mem_rd, data: mem_data, funct3: mem_funct3,
                               addr_lo: mem_addr_lo, is_load: 1'b1};
            end else if (sel_mem) begin
                mem_full_d = 1'b0;
            end
        end
    end

    always_comb begin
        write_enable_d  = drain && !bad_load && (sel_entry.rd != '0);
        illegal_load_d  = drain && bad_load;
        write_address_d = write_enable_d ? sel_entry.rd : write_address_q;
        write_data_d    = write_enable_d ? result : write_data_q;
        instret_d       = drain ? instret_q + 64'd1 : instret_q;
        rr_ptr_d        = (drain && contested) ? ~rr_ptr_q : rr_ptr_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_slot_q      <= '0;
            alu_full_q      <= 1'b0;
            mem_slot_q      <= '0;
            mem_full_q      <= 1'b0;
            rr_ptr_q        <= RR_ALU;
            write_address_q <= '0;
            write_data_q    <= '0;
            write_enable_q  <= 1'b0;
            illegal_load_q  <= 1'b0;
            instret_q       <= '0;
        end else begin
            alu_slot_q      <= alu_slot_d;
            alu_full_q      <= alu_full_d;
            mem_slot_q      <= mem_slot_d;
            mem_full_q      <= mem_full_d;
            rr_ptr_q        <= rr_ptr_d;
            write_address_q <= write_address_d;
            write_data_q    <= write_data_d;
            write_enable_q  <= write_enable_d;
            illegal_load_q  <= illegal_load_d;
            instret_q       <= instret_d;
        end
    end

    assign write_address = write_address_q;
    assign write_data    = write_data_q;
    assign write_enable  = write_enable_q;
    assign illegal_load  = illegal_load_q;
    assign instret       = instret_q;
endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: single-result vectors, arbitration, flush and reset.
module tb_writeback_unit;
    import wb_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  flush = 1'b0;
    logic                  alu_valid = 1'b0;
    logic                  alu_ready;
    logic [REG_ADDR_W-1:0] alu_rd = '0;
    logic [XLEN-1:0]       alu_data = '0;
    logic                  mem_valid = 1'b0;
    logic                  mem_ready;
    logic [REG_ADDR_W-1:0] mem_rd = '0;
    logic [XLEN-1:0]       mem_data = '0;
    logic [2:0]            mem_funct3 = '0;
    logic [1:0]            mem_addr_lo = '0;
    logic [REG_ADDR_W-1:0] write_address;
    logic [XLEN-1:0]       write_data;
    logic                  write_enable;
    logic                  illegal_load;
    logic [63:0]           instret;

    int          total = 0;
    int          bad = 0;
    logic [63:0] exp_instret = 0;
    bit          capture_en = 0;
    logic [36:0] writes_q[$];

    typedef struct {
        bit          is_load;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [2:0]  funct3;
        logic [1:0]  addr_lo;
        bit          exp_we;
        logic [31:0] exp_data;
        bit          exp_ill;
    } vec_t;

    vec_t vecs[11];

    writeback_unit dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_rd        (mem_rd),
        .mem_data      (mem_data),
        .mem_funct3    (mem_funct3),
        .mem_addr_lo   (mem_addr_lo),
        .write_address (write_address),
        .write_data    (write_data),
        .write_enable  (write_enable),
        .illegal_load  (illegal_load),
        .instret       (instret)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (capture_en && rst && write_enable)
            writes_q.push_back({write_address, write_data});
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Single result through an empty unit; starts and ends on a falling edge.
    task automatic apply_stimulus(input vec_t v);
        if (v.is_load) begin
            mem_valid = 1; mem_rd = v.rd; mem_data = v.data;
            mem_funct3 = v.funct3; mem_addr_lo = v.addr_lo;
        end else begin
            alu_valid = 1; alu_rd = v.rd; alu_data = v.data;
        end
        #1;
        check_output("ready_empty", {63'd0, v.is_load ? mem_ready : alu_ready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        alu_valid = 0; mem_valid = 0;
        @(posedge clk);
        @(negedge clk);
        exp_instret++;
        check_output("we_e1", {63'd0, write_enable}, {63'd0, v.exp_we});
        check_output("illegal_e1", {63'd0, illegal_load}, {63'd0, v.exp_ill});
        if (v.exp_we) begin
            check_output("addr_e1", {59'd0, write_address}, {59'd0, v.rd});
            check_output("data_e1", {32'd0, write_data}, {32'd0, v.exp_data});
        end
        check_output("instret_vec", instret, exp_instret);
        @(posedge clk);
        @(negedge clk);
        check_output("we_e2", {63'd0, write_enable}, 64'd0);
        check_output("illegal_e2", {63'd0, illegal_load}, 64'd0);
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [31:0] d);
        bit done = 0;
        alu_valid = 1; alu_rd = rd; alu_data = d;
        for (int k = 0; k < 40 && !done; k++) begin
            #1;
            if (alu_ready) begin
                @(posedge clk);
                done = 1;
            end
            @(negedge clk);
        end
        if (!done) check_output("alu_handshake_timeout", 64'd0, 64'd1);
    endtask

    task automatic drive_mem(input logic [4:0] rd, input logic [31:0] d);
        bit done = 0;
        mem_valid = 1; mem_rd = rd; mem_data = d; mem_funct3 = LW; mem_addr_lo = 2'b00;
        for (int k = 0; k < 40 && !done; k++) begin
            #1;
            if (mem_ready) begin
                @(posedge clk);
                done = 1;
            end
            @(negedge clk);
        end
        if (!done) check_output("mem_handshake_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        vecs[0]  = '{0, 5'd5,  32'hDEADBEEF, 3'b000, 2'd0, 1, 32'hDEADBEEF, 0};
        vecs[1]  = '{1, 5'd1,  32'h80FF7F01, 3'b000, 2'd2, 1, 32'hFFFFFFFF, 0};
        vecs[2]  = '{1, 5'd2,  32'h80FF7F01, 3'b100, 2'd3, 1, 32'h00000080, 0};
        vecs[3]  = '{1, 5'd3,  32'h80FF7F01, 3'b001, 2'd2, 1, 32'hFFFF80FF, 0};
        vecs[4]  = '{1, 5'd4,  32'h80FF7F01, 3'b101, 2'd0, 1, 32'h00007F01, 0};
        vecs[5]  = '{1, 5'd6,  32'h80FF7F01, 3'b010, 2'd1, 1, 32'h80FF7F01, 0};
        vecs[6]  = '{1, 5'd7,  32'h80FF7F01, 3'b000, 2'd1, 1, 32'h0000007F, 0};
        vecs[7]  = '{1, 5'd8,  32'h80FF7F01, 3'b001, 2'd3, 1, 32'hFFFF80FF, 0};
        vecs[8]  = '{0, 5'd0,  32'h00001234, 3'b000, 2'd0, 0, 32'h00000000, 0};
        vecs[9]  = '{1, 5'd9,  32'h12345678, 3'b011, 2'd0, 0, 32'h00000000, 1};
        vecs[10] = '{1, 5'd10, 32'h12345678, 3'b110, 2'd0, 0, 32'h00000000, 1};

        repeat (3) @(negedge clk);
        check_output("rst_we", {63'd0, write_enable}, 64'd0);
        check_output("rst_addr", {59'd0, write_address}, 64'd0);
        check_output("rst_data", {32'd0, write_data}, 64'd0);
        check_output("rst_instret", instret, 64'd0);
        rst = 1;
        @(negedge clk);
        check_output("rst_alu_ready", {63'd0, alu_ready}, 64'd1);
        check_output("rst_mem_ready", {63'd0, mem_ready}, 64'd1);

        for (int i = 0; i < 11; i++) apply_stimulus(vecs[i]);

        // Both sources offering every cycle: grants must alternate starting with ALU.
        writes_q.delete();
        capture_en = 1;
        fork
            begin
                for (int i = 0; i < 4; i++) drive_alu(5'(10 + i), 32'hA0000000 + i);
                alu_valid = 0;
            end
            begin
                for (int j = 0; j < 4; j++) drive_mem(5'(20 + j), 32'hB0000000 + j);
                mem_valid = 0;
            end
        join
        for (int k = 0; k < 100 && writes_q.size() < 8; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        capture_en = 0;
        check_output("rr_write_count", 64'(writes_q.size()), 64'd8);
        for (int i = 0; i < 8 && i < writes_q.size(); i++) begin
            logic [36:0] exp_w;
            exp_w = (i % 2 == 0) ? {5'(10 + i / 2), 32'hA0000000 + 32'(i / 2)}
                                 : {5'(20 + i / 2), 32'hB0000000 + 32'(i / 2)};
            check_output($sformatf("rr_write%0d", i), {27'd0, writes_q[i]}, {27'd0, exp_w});
        end
        exp_instret += 8;
        check_output("rr_instret", instret, exp_instret);

        // Flush with both slots full: nothing accepted, nothing written, nothing retired.
        alu_valid = 1; alu_rd = 5'd1; alu_data = 32'h11;
        mem_valid = 1; mem_rd = 5'd2; mem_data = 32'h22; mem_funct3 = LW; mem_addr_lo = 0;
        @(posedge clk);
        @(negedge clk);
        flush = 1;
        #1;
        check_output("flush_alu_ready", {63'd0, alu_ready}, 64'd0);
        check_output("flush_mem_ready", {63'd0, mem_ready}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        flush = 0; alu_valid = 0; mem_valid = 0;
        for (int k = 0; k < 4; k++) begin
            check_output("flush_no_write", {63'd0, write_enable}, 64'd0);
            @(negedge clk);
        end
        check_output("flush_instret", instret, exp_instret);
        check_output("flush_slots_empty", {63'd0, alu_ready & mem_ready}, 64'd1);

        // Asynchronous reset while both slots hold results and a write is on the port.
        alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h33;
        mem_valid = 1; mem_rd = 5'd4; mem_data = 32'h44; mem_funct3 = LW; mem_addr_lo = 0;
        @(posedge clk);
        @(negedge clk);
        alu_rd = 5'd5; alu_data = 32'h55;
        @(posedge clk);
        @(negedge clk);
        alu_valid = 0; mem_valid = 0;
        check_output("pre_reset_we", {63'd0, write_enable}, 64'd1);
        #2 rst = 0;
        #1;
        check_output("async_rst_we", {63'd0, write_enable}, 64'd0);
        check_output("async_rst_addr", {59'd0, write_address}, 64'd0);
        check_output("async_rst_data", {32'd0, write_data}, 64'd0);
        check_output("async_rst_instret", instret, 64'd0);
        @(negedge clk);
        rst = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_output("post_rst_no_write", {63'd0, write_enable}, 64'd0);
        end
        check_output("post_rst_instret", instret, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
